// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Multi-cycle multiply/divide unit with architectural HI/LO registers,
//   decoded straight from the R-type funct field. mult/multu run a radix-2
//   shift-add multiply and div/divu a restoring divide, each over WIDTH
//   cycles, then one FIX cycle applies signs and writes {hi,lo}. Fixed
//   latency of WIDTH+2 cycles from the start cycle to done.
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-high
//   start   request valid this cycle
//   funct   R-type funct field
//   a, b    rs / rt operands
//   busy    iterative operation in progress
//   done    one-cycle pulse, new hi/lo valid this cycle
//   stall   request cannot be accepted (combinational)
//   hi, lo  architectural HI/LO registers
//   result  hi for mfhi, lo for mflo, else 0 (combinational)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw;     // unmodified dividend, returned in hi on divide by zero
  logic               sign_a;
  logic               sign_b;
  logic               is_signed;
  logic               is_div;

  logic               known_op;
  logic               op_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign known_op = funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                  F_MULT, F_MULTU, F_DIV, F_DIVU};
  assign busy     = (state != IDLE);
  assign stall    = start & busy & known_op;

  // mult and div have funct[0] = 0; the unsigned forms have funct[0] = 1.
  assign op_signed = ~funct[0];
  assign mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step: shift the next dividend bit into the remainder and
  // subtract when it does not borrow. The remainder stays below the divisor,
  // so a set MSB of the difference means "borrow".
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  assign prod = (is_signed && (sign_a ^ sign_b)) ? -acc : acc;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (opb == '0) begin
        fix_lo = '1;
        fix_hi = a_raw;
      end else begin
        fix_lo = (is_signed && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi = (is_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_comb begin
    result = '0;
    if (funct == F_MFHI)      result = hi;
    else if (funct == F_MFLO) result = lo;
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      opb       <= '0;
      a_raw     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      is_signed <= 1'b0;
      is_div    <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            case (funct)
              F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                acc       <= {{WIDTH{1'b0}}, mag_a};
                opb       <= mag_b;
                a_raw     <= a;
                sign_a    <= a[WIDTH-1];
                sign_b    <= b[WIDTH-1];
                is_signed <= op_signed;
                is_div    <= funct[1];
                count     <= '0;
                state     <= funct[1] ? DIV : MUL;
              end
              F_MTHI:  hi <= a;
              F_MTLO:  lo <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc   <= mul_next;
          count <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        DIV: begin
          acc   <= div_next;
          count <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH = 32). Each iterative request pushes its
// expected {hi,lo} into a queue; a monitor pops and compares on every done
// pulse. Directed tasks additionally check latency, stall and mt/mf timing.
module tb_muldiv_unit;

  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk;
  logic         reset;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;
  int done_count = 0;
  logic [2*W-1:0] exp_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct  (funct),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        check("hilo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Issue one iterative op (called around a negedge) and track its timing
  // until done. Operands are scrambled after the start cycle.
  task automatic run_op(input string name, input logic [5:0] f,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp);
    int lat;
    int nbusy;
    start = 1'b1;
    funct = f;
    a     = av;
    b     = bv;
    exp_q.push_back(exp);
    #1;
    check({name, "_stall_at_start"}, stall, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
    lat   = 0;
    nbusy = 0;
    for (int c = 1; c <= W + 10; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, lat, W + 2);
    check({name, "_busy_cycles"}, nbusy, W + 1);
    check({name, "_busy_at_done"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstall;
    int dc;
    reset = 1'b1;
    start = 1'b0;
    funct = 6'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back: each op is issued in the done cycle of the previous one.
    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB);
    run_op("mult_min",  F_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_op("div_neg",   F_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD);
    run_op("div_negb",  F_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("divu_zero", F_DIVU,  32'd5,        32'd0,        64'h00000005_FFFFFFFF);
    run_op("div_zero",  F_DIV,   32'hFFFFFFF7, 32'd0,        64'hFFFFFFF7_FFFFFFFF);
    run_op("divu_norm", F_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E);

    // Stall test: multu 6x7 in cycle 0, mfhi held from cycle 5.
    @(posedge clk);
    #1;
    start = 1'b1;
    funct = F_MULTU;
    a     = 32'd6;
    b     = 32'd7;
    exp_q.push_back(64'd42);
    @(posedge clk);
    #1;
    start = 1'b0;                       // cycle 1
    @(posedge clk);
    #1;                                 // cycle 2: unrecognised funct while busy
    start = 1'b1;
    funct = 6'b100000;
    @(negedge clk);
    check("stall_unknown_busy", stall, 0);
    @(posedge clk);
    #1;
    start = 1'b0;                       // cycle 3
    @(posedge clk);
    #1;                                 // cycle 4
    @(posedge clk);
    #1;                                 // cycle 5
    start = 1'b1;
    funct = F_MFHI;
    nstall = 0;
    for (int c = 5; c <= 33; c++) begin
      @(negedge clk);
      if (stall) nstall++;
      @(posedge clk);
      #1;
    end
    check("stall_cycles", nstall, 29);
    @(negedge clk);                     // cycle 34
    check("stall_done_cycle", stall, 0);
    check("done_cycle34", done, 1);
    check("mfhi_after_done", result, 32'h0);
    @(posedge clk);
    #1;
    funct = F_MFLO;
    @(negedge clk);
    check("mflo_after_done", result, 32'd42);
    check("mflo_stall", stall, 0);
    start = 1'b0;

    // Reset aborts a div in flight.
    @(posedge clk);
    #1;
    start = 1'b1;
    funct = F_DIV;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;                       // cycle 1
    repeat (9) begin
      @(posedge clk);
      #1;
    end                                 // cycle 10
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;                       // cycle 11
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    dc = done_count;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_count, dc);

    // mthi/mtlo then mfhi/mflo with no stall.
    start = 1'b1;
    funct = F_MTHI;
    a     = 32'h1234;
    #1;
    check("mthi_stall", stall, 0);
    @(posedge clk);
    #1;
    funct = F_MFHI;
    a     = 32'h0;
    @(negedge clk);
    check("mfhi_result", result, 32'h1234);
    check("mfhi_stall", stall, 0);
    check("mthi_busy", busy, 0);
    funct = F_MTLO;
    a     = 32'hABCD;
    @(posedge clk);
    #1;
    funct = F_MFLO;
    @(negedge clk);
    check("mflo_result", result, 32'hABCD);

    // Unrecognised funct in IDLE changes nothing.
    funct = 6'b100000;
    a     = 32'd99;
    #1;
    check("unknown_result", result, 0);
    check("unknown_stall", stall, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("unknown_busy", busy, 0);
    check("unknown_hilo", {hi, lo}, 64'h00001234_0000ABCD);

    repeat (2) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, decoded directly from the R-type funct field. It sits beside the single-cycle ALU in the execute stage and takes the funct codes the ALU decoder does not handle: mult, multu, div, divu, mfhi, mflo, mthi and mtlo. It runs an iterative radix-2 shift-add multiply or restoring divide over WIDTH cycles. While it is busy it tells the datapath to stall.

## Interface
- WIDTH, default 32, operand/HI/LO width; legal range is WIDTH ≥ 4.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request valid this cycle (the instruction is in execute).
- funct  in  6  R-type funct field.
- a  in  WIDTH  rs operand: multiplicand, dividend, or mthi/mtlo data.
- b  in  WIDTH  rt operand: multiplier or divisor.
- busy  out  1  an iterative operation is in progress.
- done  out  1  one-cycle pulse; new HI/LO are valid this cycle.
- stall  out  1  combinational; the current request cannot be accepted, so hold the instruction.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- result  out  WIDTH  combinational; hi for mfhi, lo for mflo, otherwise 0.

## Operation
- Funct codes:
  - mfhi = 010000, mthi = 010001, mflo = 010010, mtlo = 010011.
  - mult = 011000, multu = 011001, div = 011010, divu = 011011.
  - Any other funct is ignored: no state change, stall = 0, result = 0.
- States: IDLE, MUL, DIV, FIX. busy = (state != IDLE).
- IDLE with start:
  - mult/multu goes to MUL; div/divu goes to DIV.
  - Operands are latched as magnitudes for the signed ops and raw for the unsigned ops.
  - Both sign bits are latched, and the iteration counter is cleared.
  - mthi writes hi ← a at the edge. mtlo writes lo ← a at the edge. No busy, no done.
  - mfhi/mflo only drive result; there is no state change.
- MUL: one shift-add step per cycle into a 2·WIDTH accumulator. After WIDTH steps, go to FIX.
- DIV: one restoring shift-subtract step per cycle. After WIDTH steps, go to FIX.
- FIX (one cycle):
  - Product: negate the 2·WIDTH product if the signed op has sign(a)^sign(b).
  - Quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
  - Write {hi,lo} at the edge, set done, return to IDLE.
- Product format: hi = upper WIDTH bits, lo = lower WIDTH bits.
- Division: lo = quotient, hi = remainder.
- Divide by zero (signed or unsigned) overrides the normal result: lo = all ones, hi = a as presented at start. No exception.
- Signed overflow, most-negative / −1: lo = most-negative, hi = 0. This falls out naturally from the magnitude path.
- stall = start & busy & (funct is any of the 8 codes above).
  - The request is ignored and the pipeline re-presents it later.
  - mfhi/mflo issued while busy therefore never return stale data.
- Operand inputs may change after the start cycle; the computation uses only latched values.

## Timing
- Reset values: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0.
- Reset mid-operation aborts the operation. hi/lo are cleared to 0 at that edge, and done is not pulsed.
- Iterative op accepted at the end of cycle 0:
  - busy = 1 in cycles 1..WIDTH+1 (WIDTH cycles in MUL/DIV plus 1 in FIX).
  - In cycle WIDTH+2: busy = 0, done = 1, and hi/lo hold the new values.
- Total latency is fixed at WIDTH+2 cycles from the start cycle to done, independent of operand values and signedness.
- A new start is accepted in the same cycle done is high (state is IDLE).
- A dependent mfhi/mflo in the done cycle returns the new value with stall = 0.
- mthi/mtlo/mfhi/mflo in IDLE have zero stall cycles. mt* takes effect at the next edge.
- result is purely combinational from funct, hi and lo. It is valid only when stall = 0.

## Test plan
- WIDTH = 32, multu a = 0xFFFFFFFF, b = 0xFFFFFFFF, start in cycle 0 → busy in cycles 1–33; done in cycle 34; hi = 0xFFFFFFFE, lo = 0x00000001.
- mult a = −3, b = 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- div a = −7, b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- div a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- divu a = 5, b = 0 → lo = 0xFFFFFFFF, hi = 5, with done in cycle 34.
- multu 6×7 started in cycle 0, mfhi held from cycle 5 → stall = 1 in cycles 5–33. In cycle 34, stall = 0 and result = 0x00000000; mflo then gives 42.
- reset asserted in cycle 10 of a div → busy = 0, hi = lo = 0 in cycle 11, and no done pulse.
- Afterwards, mthi 0x1234 then mfhi → result = 0x1234 with no stall.
